// File: rtl/word_des.sv
// Byte-to-word deserializer: packs an 8-bit valid/ready byte stream into WORD_BITS words.
// The accumulator doubles as a second word buffer while the output register is stalled.
module word_des #(
    parameter int WORD_BITS = 32,
    parameter int MSB_FIRST = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [7:0]           i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_align,
    output logic [WORD_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_partial
);
    localparam int unsigned NBYTES = WORD_BITS / 8;
    localparam int unsigned CW     = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] FULL = CW'(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    logic [WORD_BITS-1:0] acc;
    logic [WORD_BITS-1:0] acc_next;
    logic [WORD_BITS-1:0] out_data;
    logic [CW-1:0]        count;
    logic [CW-1:0]        base;
    logic                 out_full;
    logic                 byte_xfer;
    logic                 word_xfer;
    logic                 drained;
    int unsigned          pos;

    assign o_ready   = (count != FULL);
    assign o_valid   = out_full;
    assign o_data    = out_data;
    assign o_partial = (count != '0) && (count != FULL);

    assign byte_xfer = i_valid && o_ready;
    assign word_xfer = out_full && i_ready;
    assign drained   = !out_full || i_ready;

    // base is the slot the incoming byte takes; an align restarts the word at slot 0
    always_comb begin
        base     = i_align ? '0 : count;
        pos      = (MSB_FIRST != 0) ? (NBYTES - 1 - 32'(base)) : 32'(base);
        acc_next = acc;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (i == pos) begin
                acc_next[i*8 +: 8] = i_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count    <= '0;
            out_full <= 1'b0;
        end else if (count == FULL) begin
            if (word_xfer) begin
                count <= '0;
            end
        end else if (byte_xfer && base == LAST) begin
            if (drained) begin
                count    <= '0;
                out_full <= 1'b1;
            end else begin
                count <= FULL;
            end
        end else begin
            count <= byte_xfer ? base + CW'(1) : base;
            if (word_xfer) begin
                out_full <= 1'b0;
            end
        end
    end

    // Data path carries no reset: stale contents are never exposed once count/out_full clear
    always_ff @(posedge i_clk) begin
        if (count == FULL) begin
            if (word_xfer) begin
                out_data <= acc;
            end
        end else if (byte_xfer) begin
            if (base == LAST && drained) begin
                out_data <= acc_next;
            end else begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_word_des.sv
// Scoreboard bench for word_des: LSB-first and MSB-first instances share one stimulus stream
// and are checked against a queue-based model of held bytes and pending words.
module tb_word_des;
    localparam int NB = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_data = '0;
    logic        i_valid = 1'b0;
    logic        i_align = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ready_l, o_valid_l, o_partial_l;
    logic        o_ready_m, o_valid_m, o_partial_m;
    logic [31:0] o_data_l, o_data_m;

    word_des #(.WORD_BITS(32), .MSB_FIRST(0)) dut_l (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready_l),
        .i_align(i_align), .o_data(o_data_l), .o_valid(o_valid_l), .i_ready(i_ready),
        .o_partial(o_partial_l)
    );
    word_des #(.WORD_BITS(32), .MSB_FIRST(1)) dut_m (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready_m),
        .i_align(i_align), .o_data(o_data_m), .o_valid(o_valid_m), .i_ready(i_ready),
        .o_partial(o_partial_m)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: bytes of the word in progress, number of complete words held
    // (output register plus a full accumulator), and the scoreboard of words to emit.
    logic [7:0]  cur[$];
    int          held = 0;
    logic [31:0] exp_l[$];
    logic [31:0] exp_m[$];
    bit          started = 0;
    bit          acc_flag = 0;

    always @(posedge i_clk) begin : model
        bit rdy;
        bit wx;
        logic [31:0] wl, wm;
        acc_flag = 0;
        if (i_rst) begin
            cur.delete();
            held = 0;
            exp_l.delete();
            exp_m.delete();
            started = 1;
        end else if (started) begin
            rdy = (held < 2);
            wx  = (held > 0) && i_ready;
            if (i_align && rdy) cur.delete();
            if (wx) held--;
            if (i_valid && rdy) begin
                cur.push_back(i_data);
                acc_flag = 1;
                if (cur.size() == NB) begin
                    wl = '0;
                    wm = '0;
                    for (int k = 0; k < NB; k++) begin
                        wl = wl | (32'(cur[k]) << (8 * k));
                        wm = wm | (32'(cur[k]) << (8 * (NB - 1 - k)));
                    end
                    exp_l.push_back(wl);
                    exp_m.push_back(wm);
                    held++;
                    cur.delete();
                end
            end
        end
    end

    // Monitor: flags every cycle, words whenever a word transfer is about to happen
    int          words = 0;
    logic [31:0] last_l = '0, last_m = '0;
    logic [31:0] prev_l, prev_m;
    bit          prev_stall = 0;

    always @(negedge i_clk) begin
        if (started) begin
            chk("o_valid_l", o_valid_l, held > 0);
            chk("o_ready_l", o_ready_l, held < 2);
            chk("o_partial_l", o_partial_l, cur.size() > 0);
            chk("o_valid_m", o_valid_m, held > 0);
            chk("o_ready_m", o_ready_m, held < 2);
            chk("o_partial_m", o_partial_m, cur.size() > 0);
            if (prev_stall) begin
                chk("stall_hold_l", o_data_l, prev_l);
                chk("stall_hold_m", o_data_m, prev_m);
            end
            if (o_valid_l && i_ready && !i_rst) begin
                if (exp_l.size() == 0 || exp_m.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h/%0h expected none", o_data_l, o_data_m);
                end else begin
                    chk("word_lsb", o_data_l, exp_l.pop_front());
                    chk("word_msb", o_data_m, exp_m.pop_front());
                    last_l = o_data_l;
                    last_m = o_data_m;
                    words++;
                end
            end
            prev_stall = o_valid_l && !i_ready && !i_rst;
            prev_l = o_data_l;
            prev_m = o_data_m;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        i_valid = 1'b1;
        i_data  = b;
        t = 0;
        do begin
            tick();
            t++;
        end while (!acc_flag && t < 100);
        if (!acc_flag) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte %0h not accepted within %0d cycles", b, t);
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int sent;
        int cyc;
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("reset_ready", o_ready_l, 1);
        chk("reset_valid", o_valid_l, 0);
        #1;

        // Four bytes back to back, output always ready
        i_ready = 1'b1;
        w0 = words;
        send(8'hDD); send(8'hCC); send(8'hBB); send(8'hAA);
        idle(3);
        chk("basic_count", words - w0, 1);
        chk("basic_lsb", last_l, 32'hAABBCCDD);
        chk("basic_msb", last_m, 32'hDDCCBBAA);

        // Output stalled: second word parks in the accumulator and blocks input
        i_ready = 1'b0;
        w0 = words;
        for (int b = 1; b <= 8; b++) send(8'(b));
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("stall_ready_low", o_ready_l, 0);
        chk("stall_data", o_data_l, 32'h04030201);
        #1;
        idle(3);
        i_ready = 1'b1;
        idle(4);
        chk("stall_count", words - w0, 2);
        chk("stall_last", last_l, 32'h08070605);

        // Partial word discarded by align
        w0 = words;
        send(8'h11);
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("partial_high", o_partial_l, 1);
        #1;
        send(8'h22);
        i_valid = 1'b0;
        i_align = 1'b1;
        tick();
        i_align = 1'b0;
        @(negedge i_clk);
        chk("align_partial_low", o_partial_l, 0);
        #1;
        send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        idle(3);
        chk("align_count", words - w0, 1);
        chk("align_word", last_l, 32'h66554433);

        // Align on the same edge as a byte: that byte starts the new word
        w0 = words;
        send(8'hA0); send(8'hA1);
        i_align = 1'b1;
        send(8'hB0);
        i_align = 1'b0;
        send(8'hB1); send(8'hB2); send(8'hB3);
        idle(3);
        chk("align_byte_count", words - w0, 1);
        chk("align_byte_word", last_l, 32'hB3B2B1B0);

        // Reset mid-word, and reset with both buffers full
        w0 = words;
        send(8'h11); send(8'h22);
        i_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(3);
        chk("rst_count", words - w0, 1);
        chk("rst_word", last_l, 32'h44332211);
        i_ready = 1'b0;
        w0 = words;
        for (int b = 0; b < 8; b++) send(8'(b + 8'h40));
        i_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_ready = 1'b1;
        idle(4);
        chk("rst_full_dropped", words - w0, 0);

        // Random handshakes over a counting sequence
        w0 = words;
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = 1'($urandom_range(0, 1));
            i_data  = 8'(sent);
            tick();
            cyc++;
            if (acc_flag) sent++;
        end
        chk("rand_bytes_sent", sent, 1000);
        i_valid = 1'b0;
        i_ready = 1'b1;
        idle(5);
        chk("rand_word_count", words - w0, 250);
        chk("scoreboard_empty", exp_l.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
